// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI peripheral controller.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RLOAD,
        RDATA,
        WDATA
    } spi_state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Bit counter must reach the longer of header and data word.
    function automatic int cnt_width(input int hdr_w, input int data_w);
        return $clog2(((hdr_w > data_w) ? hdr_w : data_w) + 1);
    endfunction

endpackage

// File: rtl/spi_periph_ctrl_if.sv
// Synchronous memory port between the SPI controller and peripheral memory.
interface spi_periph_ctrl_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_addr, mem_wdata, mem_we, mem_re, input mem_rdata);
    modport slave  (input mem_addr, mem_wdata, mem_we, mem_re, output mem_rdata);
endinterface

// File: rtl/spi_shift_reg.sv
// Shift register: serial-in/parallel-out plus parallel-load/serial-out (MSB first).
module spi_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             load_en,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] par_out,
    output logic             ser_out
);
    logic [WIDTH-1:0] q;

    // Load takes priority over shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        q <= '0;
        else if (load_en)  q <= load_val;
        else if (shift_en) q <= {q[WIDTH-2:0], ser_in};
    end

    assign par_out = q;
    assign ser_out = q[WIDTH-1];
endmodule

// File: rtl/spi_periph_ctrl.sv
// SPI mode-0 peripheral controller: header decode, write/read data, memory port.
// Optional burst transfers (auto-incrementing address) under `define SPI_BURST_EN.
module spi_periph_ctrl
    import spi_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_n,
    input  logic sclk_rise,
    input  logic sclk_fall,
    input  logic mosi,
    output logic miso,
    output logic miso_oe,
    output logic busy,
    output logic frame_err,
    spi_periph_ctrl_if.master mem
);
    localparam int HDR_W  = ADDR_W + 1;
    // The final bit of a word is taken straight from mosi, so one bit less is stored.
    localparam int SR_W   = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
    localparam int CNT_W  = cnt_width(HDR_W, DATA_W);
    localparam int STAGES = RD_LAT + 1;
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [SR_W-1:0]   sr_q;
    logic [DATA_W-1:0] tx_q;
    logic              sr_msb, tx_msb;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q, oe_q, miso_q, ferr_q;
    // vld_pipe[0]: first RLOAD clk, [1]: mem_re, [STAGES]: rdata valid
    logic [STAGES:0]   vld_pipe;

    logic abort, rise, fall, hdr_done, word_done, rd_done, wr_done, rd_go, capture;

    assign abort     = cs_n && (state_q != IDLE);
    assign rise      = sclk_rise && !cs_n;
    assign fall      = sclk_fall && !cs_n;
    assign hdr_done  = (state_q == HDR) && rise && (cnt_q == HDR_LAST);
    assign word_done = (state_q == RDATA || state_q == WDATA) && rise && (cnt_q == DATA_LAST);
    assign rd_done   = word_done && (state_q == RDATA);
    assign wr_done   = word_done && (state_q == WDATA);
    assign capture   = (state_q == RLOAD) && vld_pipe[STAGES] && !cs_n;
`ifdef SPI_BURST_EN
    assign rd_go     = (hdr_done && mosi == RW_READ) || rd_done;
`else
    assign rd_go     = hdr_done && mosi == RW_READ;
`endif

    // Header / write-data capture path
    spi_shift_reg #(.WIDTH(SR_W)) u_rx_sr (
        .clk, .rst_n,
        .shift_en (rise && (state_q == HDR || state_q == WDATA)),
        .load_en  (1'b0),
        .ser_in   (mosi),
        .load_val ('0),
        .par_out  (sr_q),
        .ser_out  (sr_msb)
    );

    // Read-data transmit path
    spi_shift_reg #(.WIDTH(DATA_W)) u_tx_sr (
        .clk, .rst_n,
        .shift_en (fall && state_q == RDATA),
        .load_en  (capture),
        .ser_in   (1'b0),
        .load_val (mem.mem_rdata),
        .par_out  (tx_q),
        .ser_out  (tx_msb)
    );

    logic unused_sr;
    assign unused_sr = ^{sr_q, sr_msb, tx_q};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; CS deassertion overrides everything
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (!cs_n) state_d = HDR;
            HDR:   if (hdr_done) state_d = (mosi == RW_READ) ? RLOAD : WDATA;
            RLOAD: if (capture) state_d = RDATA;
`ifdef SPI_BURST_EN
            RDATA: if (word_done) state_d = RLOAD;
            WDATA: if (word_done) state_d = WDATA;
`else
            RDATA: if (word_done) state_d = HDR;
            WDATA: if (word_done) state_d = HDR;
`endif
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Bit counter: counts accepted rises, cleared at every word boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (abort || state_q == IDLE || hdr_done || word_done)
            cnt_q <= '0;
        else if (rise && (state_q == HDR || state_q == RDATA || state_q == WDATA))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    // Memory strobes, address/data latches, MISO and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            oe_q     <= 1'b0;
            miso_q   <= 1'b0;
            ferr_q   <= 1'b0;
            vld_pipe <= '0;
        end else begin
            we_q     <= 1'b0;
            ferr_q   <= abort && (cnt_q != '0 || state_q == RLOAD);
            vld_pipe <= abort ? '0 : {vld_pipe[STAGES-1:0], rd_go};
            if (hdr_done) addr_q <= sr_q[ADDR_W-1:0];
            if (wr_done) begin
                wdata_q <= {sr_q[DATA_W-2:0], mosi};
                we_q    <= 1'b1;
            end
`ifdef SPI_BURST_EN
            // Bump after the write strobe, or before the next read strobe
            if (we_q || rd_done) addr_q <= addr_q + ADDR_W'(1);
`endif
            if (fall && state_q == RDATA) miso_q <= tx_msb;
            if (abort || rd_done) oe_q <= 1'b0;
            else if (capture)     oe_q <= 1'b1;
        end
    end

    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_re    = vld_pipe[1];
    assign miso          = miso_q;
    assign miso_oe       = oe_q;
    assign busy          = (state_q != IDLE);
    assign frame_err     = ferr_q;
endmodule
